// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Arbitrates two sram-like requesters (inst, data) onto one shared
//   sram-like bus port. A requester that has been granted but has not yet
//   seen bus_addr_ok is locked onto the bus. Responses are routed back in
//   order using a FIFO of requester IDs.
//
// Parameters
//   OUTSTANDING : maximum number of accepted-but-unanswered requests
//                 (power of two, 2..8)
// Ports
//   clk, reset                        clock, async active-high reset
//   inst_* / data_*                   requester sides (req, wr, size, wstrb,
//                                     addr, wdata in; addr_ok, data_ok,
//                                     rdata out)
//   bus_*                             shared bus side
//   arb_err                           sticky flag: response with no
//                                     outstanding request
// Build option
//   ARB_ROUND_ROBIN_EN : when defined, ties alternate using a last_grant
//                        register; when undefined, ties go to data.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        arb_err
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t                 r_state, w_next;
  logic [OUTSTANDING-1:0] r_ids;
  logic [PW-1:0]          r_wp, r_rp;
  logic [CW-1:0]          r_cnt;
  logic                   r_err;
  logic                   w_full, w_empty, w_gnt, w_id, w_tie_id;
  logic                   w_push, w_pop;

  assign w_full  = (r_cnt == CW'(OUTSTANDING));
  assign w_empty = (r_cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;  // 0 = inst, 1 = data
  assign w_tie_id = ~r_last_grant;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_last_grant <= 1'b0;
    else if (w_push) r_last_grant <= w_id;
  end
`else
  assign w_tie_id = 1'b1;
`endif

  // Grant / next-state. w_id: 0 = inst, 1 = data.
  always_comb begin
    w_gnt  = 1'b0;
    w_id   = 1'b0;
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!w_full) begin
          if (inst_req && data_req) begin w_gnt = 1'b1; w_id = w_tie_id; end
          else if (inst_req)        begin w_gnt = 1'b1; w_id = 1'b0; end
          else if (data_req)        begin w_gnt = 1'b1; w_id = 1'b1; end
        end
        if (w_gnt && !bus_addr_ok) w_next = w_id ? LOCK_D : LOCK_I;
      end
      LOCK_I: begin
        // Dropped request abandons the lock without a push.
        if (!inst_req) w_next = IDLE;
        else begin
          w_id  = 1'b0;
          w_gnt = !w_full;  // lock held, but bus_req masked while full
          if (w_gnt && bus_addr_ok) w_next = IDLE;
        end
      end
      LOCK_D: begin
        if (!data_req) w_next = IDLE;
        else begin
          w_id  = 1'b1;
          w_gnt = !w_full;
          if (w_gnt && bus_addr_ok) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (reset) w_gnt = 1'b0;
  end

  assign bus_req   = w_gnt;
  assign bus_wr    = w_gnt ? (w_id ? data_wr    : inst_wr)    : 1'b0;
  assign bus_size  = w_gnt ? (w_id ? data_size  : inst_size)  : 2'd0;
  assign bus_wstrb = w_gnt ? (w_id ? data_wstrb : inst_wstrb) : 4'd0;
  assign bus_addr  = w_gnt ? (w_id ? data_addr  : inst_addr)  : 32'd0;
  assign bus_wdata = w_gnt ? (w_id ? data_wdata : inst_wdata) : 32'd0;

  assign w_push = w_gnt && bus_addr_ok;
  assign w_pop  = bus_data_ok && !w_empty && !reset;

  assign inst_addr_ok = w_push && !w_id;
  assign data_addr_ok = w_push &&  w_id;
  assign inst_data_ok = w_pop && !r_ids[r_rp];
  assign data_data_ok = w_pop &&  r_ids[r_rp];
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign arb_err      = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ids   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) begin
        r_ids[r_wp] <= w_id;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (bus_data_ok && w_empty) r_err <= 1'b1;
    end
  end
endmodule
